// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO into a valid/ready stream through a 2-entry buffer
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  areset_b,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  beat_count
);
  logic [1:0] occ, level;
  logic inflight, wptr, rptr, pop;
  logic [DATA_WIDTH-1:0] ent [2];
  assign m_valid = occ != 2'd0;
  assign m_data = ent[rptr];
  assign pop = m_valid & m_ready;
  assign level = occ + {1'b0, inflight} - {1'b0, pop};
  // gated by reset so no read can be lost while the buffer is being cleared
  assign fifo_read = areset_b & enable & ~fifo_empty & (level < 2'd2);
  always_ff @(posedge clk or negedge areset_b)
    if (!areset_b) begin
      occ <= 2'd0;
      inflight <= 1'b0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      ent[0] <= '0;
      ent[1] <= '0;
      beat_count <= '0;
    end else begin
      inflight <= fifo_read;
      occ <= level;
      if (inflight) begin
        ent[wptr] <= fifo_data;
        wptr <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a bench-side FIFO model and scoreboard
module tb_fifo_rd_stream;
  logic clk = 1'b0, areset_b = 1'b0, enable = 1'b0, m_ready = 1'b0, force_empty = 1'b0;
  logic [15:0] fifo_data = 16'h0;
  logic fifo_empty, fifo_read, m_valid, fifo_read4, m_valid4;
  logic [15:0] m_data, m_data4;
  logic [31:0] beat_count;
  logic [3:0] beat_count4;
  logic [15:0] mem [0:2047];
  int rd_idx = 0, wr_idx = 0, dv_idx = 0, checks = 0, failures = 0;
  int cyc = 0, nreads = 0, first_rd = -1, first_vld = -1, last_pop = -1, n0 = 0;
  logic [31:0] exp_beats = 32'h0, b0 = 32'h0;
  logic stall = 1'b0, rd_now = 1'b0;
  logic [15:0] hold_d = 16'h0, last_data = 16'h0;

  assign fifo_empty = force_empty | (rd_idx == wr_idx);
  always #5 clk = ~clk;

  fifo_rd_stream u_dut (
    .clk(clk), .areset_b(areset_b), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .beat_count(beat_count)
  );

  fifo_rd_stream #(.DATA_WIDTH(16), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .areset_b(areset_b), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .beat_count(beat_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_idx] = v;
    wr_idx++;
  endtask

  // one clock: check outputs at the falling edge, model the FIFO read latency after the rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("read_while_empty", {31'b0, fifo_read & fifo_empty}, 32'd0);
    chk("read_while_empty4", {31'b0, fifo_read4 & fifo_empty}, 32'd0);
    chk("beat_count", beat_count, exp_beats);
    chk("beat_count4", {28'b0, beat_count4}, {28'b0, exp_beats[3:0]});
    if (stall) begin
      chk("hold_valid", {31'b0, m_valid}, 32'd1);
      chk("hold_data", {16'b0, m_data}, {16'b0, hold_d});
    end
    rd_now = fifo_read;
    if (fifo_read) begin
      nreads++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid4 & m_ready) chk("data4", {16'b0, m_data4}, {16'b0, mem[dv_idx]});
    if (m_valid & m_ready) begin
      chk("data", {16'b0, m_data}, {16'b0, mem[dv_idx]});
      dv_idx++;
      exp_beats++;
      last_data = m_data;
      last_pop = cyc;
    end
    stall = m_valid & ~m_ready;
    hold_d = m_data;
    @(posedge clk);
    #1;
    if (rd_now) begin
      fifo_data = mem[rd_idx];
      rd_idx++;
    end
    chk("outstanding_le2", {31'b0, (rd_idx - dv_idx) <= 2}, 32'd1);
  endtask

  task automatic do_reset();
    areset_b = 1'b0;
    #1;
    chk("rst_fifo_read", {31'b0, fifo_read}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", {16'b0, m_data}, 32'd0);
    chk("rst_beat_count", beat_count, 32'd0);
    chk("rst_beat_count4", {28'b0, beat_count4}, 32'd0);
    dv_idx = rd_idx;
    exp_beats = 32'h0;
    stall = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    tick();
    tick();
    areset_b = 1'b1;
    // streaming 16 words with an always-ready consumer
    for (int i = 1; i <= 16; i++) push(16'(i));
    enable = 1'b1;
    m_ready = 1'b1;
    first_rd = -1;
    first_vld = -1;
    repeat (24) tick();
    chk("stream_latency", first_vld - first_rd, 32'd2);
    chk("stream_back_to_back", last_pop - first_vld, 32'd15);
    chk("stream_count", beat_count, 32'd16);
    chk("stream_wrap4", {28'b0, beat_count4}, 32'd0);
    chk("stream_drained", dv_idx, wr_idx);
    // backpressure
    m_ready = 1'b0;
    n0 = nreads;
    for (int i = 1; i <= 8; i++) push(16'(i));
    repeat (6) tick();
    chk("bp_reads", nreads - n0, 32'd2);
    chk("bp_valid", {31'b0, m_valid}, 32'd1);
    chk("bp_data", {16'b0, m_data}, 32'h1);
    m_ready = 1'b1;
    repeat (14) tick();
    chk("bp_drained", dv_idx, wr_idx);
    chk("bp_total_reads", nreads - n0, 32'd8);
    chk("bp_count", beat_count, 32'd24);
    // single word then empty
    n0 = nreads;
    push(16'hBEEF);
    repeat (6) tick();
    chk("empty_reads", nreads - n0, 32'd1);
    chk("empty_count", beat_count, 32'd25);
    chk("empty_data", {16'b0, last_data}, 32'hBEEF);
    chk("empty_valid_low", {31'b0, m_valid}, 32'd0);
    // enable drop right after a read
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'h0A00 + 16'(i));
    tick();
    chk("en_off_no_read", nreads - n0, 32'd1);
    n0 = nreads;
    enable = 1'b1;
    tick();
    chk("en_read", nreads - n0, 32'd1);
    enable = 1'b0;
    repeat (5) tick();
    chk("en_no_more_reads", nreads - n0, 32'd1);
    chk("en_inflight_delivered", {16'b0, last_data}, 32'h0A01);
    chk("en_count", beat_count, 32'd26);
    enable = 1'b1;
    tick();
    chk("en_resume", nreads - n0, 32'd2);
    repeat (8) tick();
    chk("en_drained", dv_idx, wr_idx);
    // reset with a full buffer
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'h0C00 + 16'(i));
    repeat (4) tick();
    chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    chk("pre_rst_outstanding", rd_idx - dv_idx, 32'd2);
    do_reset();
    force_empty = 1'b1;
    m_ready = 1'b1;
    tick();
    areset_b = 1'b1;
    n0 = nreads;
    repeat (3) tick();
    chk("post_rst_no_read", nreads - n0, 32'd0);
    chk("post_rst_valid_low", {31'b0, m_valid}, 32'd0);
    force_empty = 1'b0;
    repeat (8) tick();
    chk("post_rst_drained", dv_idx, wr_idx);
    chk("post_rst_count", beat_count, 32'd2);
    chk("post_rst_last", {16'b0, last_data}, 32'h0C04);
    // random backpressure and empty gaps
    b0 = exp_beats;
    for (int i = 0; i < 1000; i++) push(16'($urandom));
    for (int t = 0; t < 20000 && dv_idx < wr_idx; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0);
      tick();
    end
    chk("rand_drained", dv_idx, wr_idx);
    chk("rand_count", beat_count, b0 + 32'd1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Downstream drain stage for the FIFO memory block: issues reads into the FIFO whenever it is non-empty and space is available, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the data as a valid/ready stream. It sustains one word per cycle to an always-ready consumer and never reads an empty FIFO. A free-running beat counter reports delivered words for bench and status use.

## Interface
- DATA_WIDTH, 16, width of FIFO data and stream data
- CNT_WIDTH, 32, width of delivered-beat counter
- clk  input  1  single clock, all logic rising-edge
- areset_b  input  1  asynchronous, active-low reset
- enable  input  1  1 = new FIFO reads permitted; 0 = no new reads, in-flight read still completes and buffered data still drains
- fifo_empty  input  1  empty indicator from FIFO (current-cycle state)
- fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_read
- fifo_read  output  1  read strobe to FIFO (connects to FIFO trans_read)
- m_valid  output  1  stream data valid
- m_ready  input  1  stream consumer ready
- m_data  output  DATA_WIDTH  stream data
- beat_count  output  CNT_WIDTH  number of m_valid&m_ready beats since reset, wraps

## Operation
- State: buffer of 2 entries (occ 0..2), in-flight flag inflight (1 = fifo_read was high last cycle), read/write pointers 1 bit each.
- pop = m_valid & m_ready.
- fifo_read = enable & ~fifo_empty & ((occ + inflight - pop) < 2); combinational from registered state, enable, fifo_empty and m_ready (documented path m_ready -> fifo_read).
- inflight <= fifo_read each cycle.
- When inflight = 1, fifo_data written into buffer at wptr on that clock edge; wptr toggles.
- m_valid = (occ != 0); m_data = entry at rptr; on pop, rptr toggles.
- occ next = occ + inflight - pop; occ never exceeds 2, never underflows (guaranteed by read condition; bench asserts it).
- Simultaneous capture and pop: both applied same edge; order-preserving FIFO semantics, first captured = first delivered.
- beat_count increments by 1 on every pop; wraps 2^CNT_WIDTH-1 -> 0.
- m_data held stable while m_valid=1 and m_ready=0 (AXI-style: valid never drops without a pop).
- enable falling with a read in flight: that word is still captured and delivered; no further reads.
- fifo_empty rising in the same cycle the read condition would be met: no read issued.
- No FIFO overflow/underflow ever caused by this block.

## Timing
- Reset (areset_b=0, async): occ=0, inflight=0, pointers=0, buffer contents=0, beat_count=0; therefore fifo_read=0, m_valid=0, m_data=0 immediately.
- Reset deassertion: first fifo_read possible in the first cycle after release if fifo_empty=0 and enable=1.
- Latency: fifo_read high in cycle N -> word in buffer end of N+1 -> m_valid=1 in cycle N+2 (when buffer was empty).
- Throughput: m_ready held 1, FIFO non-empty -> one beat per cycle steady state (occ=1, inflight=1).
- Backpressure: m_ready=0 -> at most 2 words outstanding (occ+inflight<=2); fifo_read stops within the same cycle occ+inflight reaches 2.
- Reset asserted mid-operation: buffered and in-flight words discarded (already popped from FIFO); outputs return to reset values asynchronously.

## Test plan
- Reset: areset_b=0 mid-stream with occ=2 -> fifo_read, m_valid, m_data, beat_count all 0 same cycle, no glitch after release until FIFO non-empty.
- Streaming: FIFO preloaded 0x0001..0x0010, m_ready=1, enable=1 -> first m_valid 2 cycles after first fifo_read, 16 consecutive beats in order, beat_count=16.
- Backpressure: 8 words, m_ready=0 -> exactly 2 fifo_read pulses then none, m_data=0x0001 held; m_ready=1 -> 0x0001..0x0008 in order, no loss or duplicate.
- Empty boundary: single word 0xBEEF, then fifo_empty=1 -> exactly one fifo_read, one beat 0xBEEF, m_valid deasserts, fifo_read never high while fifo_empty=1.
- Enable: drop enable in the cycle after a fifo_read -> in-flight word delivered, no further reads; re-raise -> reads resume next cycle.
- Random m_ready (50%) over 1000 words with random fifo_empty -> scoreboard order match, occ never >2, beat_count=1000; counter wrap checked with CNT_WIDTH=4 (16 beats -> 0).
